// File: rtl/ddr_align_pkg.sv
// rtl/ddr_align_pkg.sv - shared state encoding and default limits for DDR lane alignment
package ddr_align_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_SETTLE    = 3'd2,
    ST_KICK      = 3'd3,
    ST_WAIT_RES  = 3'd4,
    ST_RETRY     = 3'd5,
    ST_NEXT      = 3'd6,
    ST_TERM      = 3'd7
  } align_state_t;

  localparam int          DEF_TMO_WIDTH = 12;
  localparam logic [11:0] DEF_TMO_MAX   = 12'hfff;
  localparam int          DEF_MAX_RETRY = 3;

  // One-hot lane decode sized for the 8-lane maximum; callers truncate.
  function automatic logic [7:0] lane_bit(input logic [2:0] idx);
    return 8'd1 << idx;
  endfunction

endpackage

// File: rtl/align_attempt_tmr.sv
// rtl/align_attempt_tmr.sv - saturating cycle counter with clear, shared by settle, pulse and timeout phases
module align_attempt_tmr #(
  parameter int               WIDTH = 12,
  parameter logic [WIDTH-1:0] MAX   = '1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] cnt,
  output logic             at_max
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != MAX)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign at_max = (cnt == MAX);

endmodule

// File: rtl/ddr_lane_align_sched.sv
// rtl/ddr_lane_align_sched.sv - trains DDR byte-lane read alignment one lane at a time
// with per-attempt timeout, bounded retries and a per-lane failure mask.
module ddr_lane_align_sched
  import ddr_align_pkg::*;
#(
  parameter int                   NUM_LANES     = 2,
  parameter int                   TMO_WIDTH     = DEF_TMO_WIDTH,
  parameter logic [TMO_WIDTH-1:0] TMO_MAX       = DEF_TMO_MAX,
  parameter int                   MAX_RETRY     = DEF_MAX_RETRY,
  parameter int                   SETTLE_CYCLES = 16,
  parameter int                   RST_PULSE     = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 lock,
  input  logic [NUM_LANES-1:0] lane_good,
  input  logic [NUM_LANES-1:0] lane_err,
  output logic [NUM_LANES-1:0] lane_rst_dp,
  output logic                 train_en,
  output logic [2:0]           lane_sel,
  output logic                 busy,
  output logic                 done,
  output logic                 fail,
  output logic [NUM_LANES-1:0] fail_mask,
  output logic [2:0]           retry_cnt
);

  localparam logic [TMO_WIDTH-1:0] SETTLE_LAST = TMO_WIDTH'(SETTLE_CYCLES - 1);
  localparam logic [TMO_WIDTH-1:0] PULSE_LAST  = TMO_WIDTH'(RST_PULSE - 1);
  localparam logic [2:0]           LAST_LANE   = 3'(NUM_LANES - 1);
  localparam logic [2:0]           RETRY_LIM   = 3'(MAX_RETRY);

  align_state_t         state, state_nx;
  logic [2:0]           lane_nx, retry_nx;
  logic [NUM_LANES-1:0] mask_nx, sel_bits;
  logic                 good_cur, err_cur, good_q;
  logic                 tmr_clr, tmo_hit;
  logic [TMO_WIDTH-1:0] tmr_cnt;

  // One counter serves every timed phase; it restarts on each state change.
  assign tmr_clr = (state_nx != state);

  align_attempt_tmr #(
    .WIDTH (TMO_WIDTH),
    .MAX   (TMO_MAX)
  ) u_tmr (
    .clk    (clk),
    .rst_n  (reset_n),
    .clr    (tmr_clr),
    .en     (1'b1),
    .cnt    (tmr_cnt),
    .at_max (tmo_hit)
  );

  assign sel_bits = NUM_LANES'(lane_bit(lane_sel));
  assign good_cur = |(lane_good & sel_bits);
  assign err_cur  = |(lane_err & sel_bits);

  assign busy     = (state != ST_IDLE) && (state != ST_TERM);
  assign train_en = (state == ST_KICK) || (state == ST_WAIT_RES);

  always_comb begin
    state_nx = state;
    lane_nx  = lane_sel;
    retry_nx = retry_cnt;
    mask_nx  = fail_mask;
    case (state)
      ST_IDLE, ST_TERM: begin
        if (start) begin
          state_nx = ST_WAIT_LOCK;
          lane_nx  = 3'd0;
          retry_nx = 3'd0;
          mask_nx  = '0;
        end
      end
      ST_WAIT_LOCK: if (lock) state_nx = ST_SETTLE;
      ST_SETTLE:    if (tmr_cnt == SETTLE_LAST) state_nx = ST_KICK;
      ST_KICK:      if (tmr_cnt == PULSE_LAST) state_nx = ST_WAIT_RES;
      ST_WAIT_RES: begin
        // err wins over a simultaneous good; pass needs good on two consecutive samples
        if (err_cur) state_nx = ST_RETRY;
        else if (good_cur && good_q) state_nx = ST_NEXT;
        else if (tmo_hit) state_nx = ST_RETRY;
      end
      ST_RETRY: begin
        if (retry_cnt < RETRY_LIM) begin
          retry_nx = retry_cnt + 3'd1;
          state_nx = ST_KICK;
        end else begin
          mask_nx  = fail_mask | sel_bits;
          state_nx = ST_NEXT;
        end
      end
      ST_NEXT: begin
        if (lane_sel == LAST_LANE) begin
          state_nx = ST_TERM;
        end else begin
          lane_nx  = lane_sel + 3'd1;
          retry_nx = 3'd0;
          state_nx = ST_KICK;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
    if (!lock && (state >= ST_SETTLE) && (state <= ST_NEXT)) begin
      state_nx = ST_WAIT_LOCK;
      lane_nx  = 3'd0;
      retry_nx = 3'd0;
      mask_nx  = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      lane_sel    <= 3'd0;
      retry_cnt   <= 3'd0;
      fail_mask   <= '0;
      good_q      <= 1'b0;
      lane_rst_dp <= '0;
      done        <= 1'b0;
      fail        <= 1'b0;
    end else begin
      state       <= state_nx;
      lane_sel    <= lane_nx;
      retry_cnt   <= retry_nx;
      fail_mask   <= mask_nx;
      good_q      <= (state == ST_WAIT_RES) && good_cur && !err_cur;
      // Decoded from next state so the pulse is flop-driven and aligned with KICK.
      lane_rst_dp <= (state_nx == ST_KICK) ? NUM_LANES'(lane_bit(lane_nx)) : '0;
      done        <= (state_nx == ST_TERM) && (mask_nx == '0) && lock;
      fail        <= (state_nx == ST_TERM) && (mask_nx != '0);
    end
  end

endmodule
